// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron layer.
// Optional refractory logic is controlled by the LIF_REFRAC_EN macro.
package lif_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_THRESHOLD = 200;
    localparam int REFRAC_W      = 4;

    // Address width for an N-entry index; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lif_neuron.sv
// One LIF neuron: shift leak, saturating integrate, threshold with reset-by-subtraction.
// Latency: current sampled at an edge, spike and new state visible after that edge.
// Backpressure: none; spike_nxt is a combinational preview for the event queue. Macro: LIF_REFRAC_EN.
module lif_neuron
    import lif_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int THRESHOLD     = DEF_THRESHOLD,
    parameter int REFRAC_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] current,
    input  logic [2:0]       beta,
    output logic             spike_nxt,
    output logic             spike,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

    logic [WIDTH:0]   sum_w;
    logic [WIDTH-1:0] sat;
    logic             busy;

    // state - (state >> beta) never underflows, so one extra bit covers the add.
    assign sum_w     = {1'b0, state} - {1'b0, state >> beta} + {1'b0, current};
    assign sat       = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
    assign spike_nxt = en && !busy && (sat >= THR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            spike <= 1'b0;
        end else begin
            spike <= spike_nxt;
            if (en && !busy)
                state <= spike_nxt ? (sat - THR) : sat;
        end
    end

`ifdef LIF_REFRAC_EN
    localparam logic [REFRAC_W-1:0] REFRAC_LOAD = REFRAC_W'(REFRAC_CYCLES);

    logic [REFRAC_W-1:0] refrac_cnt;

    assign busy = (refrac_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refrac_cnt <= '0;
        end else if (en) begin
            if (busy)
                refrac_cnt <= refrac_cnt - 1'b1;
            else if (spike_nxt)
                refrac_cnt <= REFRAC_LOAD;
        end
    end
`else
    localparam int unused_refrac_cycles = REFRAC_CYCLES;

    assign busy = 1'b0;
`endif

endmodule

// File: rtl/lif_array.sv
// Layer of N LIF neurons with a pending-spike bitmask drained lowest-index-first.
// Latency: spike and evt_valid rise one edge after the sampling edge; mon_state is combinational.
// Backpressure: evt_ready low holds events pending; a re-spike on a held bit sets sticky evt_overflow.
module lif_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS     = 4,
    parameter int WIDTH         = DEF_WIDTH,
    parameter int THRESHOLD     = DEF_THRESHOLD,
    parameter int REFRAC_CYCLES = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic [N_NEURONS*WIDTH-1:0]          current,
    input  logic [2:0]                          beta,
    output logic [N_NEURONS-1:0]                spike,
    output logic                                evt_valid,
    input  logic                                evt_ready,
    output logic [clog2_min1(N_NEURONS)-1:0]    evt_addr,
    output logic                                evt_overflow,
    input  logic [clog2_min1(N_NEURONS)-1:0]    mon_sel,
    output logic [WIDTH-1:0]                    mon_state
);

    localparam int AW = clog2_min1(N_NEURONS);

    logic [N_NEURONS-1:0] spike_nxt;
    logic [N_NEURONS-1:0] pending;
    logic [N_NEURONS-1:0] accepted;
    logic [WIDTH-1:0]     states [N_NEURONS];

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
        lif_neuron #(
            .WIDTH         (WIDTH),
            .THRESHOLD     (THRESHOLD),
            .REFRAC_CYCLES (REFRAC_CYCLES)
        ) u_neuron (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .current   (current[g*WIDTH +: WIDTH]),
            .beta      (beta),
            .spike_nxt (spike_nxt[g]),
            .spike     (spike[g]),
            .state     (states[g])
        );
    end

    assign evt_valid = |pending;

    // Fixed priority: the lowest set index wins.
    always_comb begin
        evt_addr = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending[i])
                evt_addr = AW'(i);
        end
    end

    always_comb begin
        accepted = '0;
        for (int i = 0; i < N_NEURONS; i++)
            accepted[i] = evt_valid && evt_ready && (evt_addr == AW'(i));
    end

    // An accepted bit may be re-set by a same-cycle spike without counting as a loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            evt_overflow <= 1'b0;
        end else begin
            pending <= (pending & ~accepted) | spike_nxt;
            if (|(spike_nxt & pending & ~accepted))
                evt_overflow <= 1'b1;
        end
    end

    always_comb begin
        mon_state = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (mon_sel == AW'(i))
                mon_state = states[i];
        end
    end

endmodule
